k_rd_packer_t1: RTL and testbench

- Read-domain consumer for the 2-deep synchronizing FIFO's rrdy/rget/rdata interface.
- Pops data_size-bit entries whenever they are available.
- Packs n_lanes consecutive entries into one wide word. The first entry popped goes into the least-significant lane.
- Presents the packed word on a valid/ready output toward the downstream read-domain logic.

---
 rtl/k_rd_packer_t1.sv | 149 ++++++++++++++
 tb/tb_k_rd_packer_t1.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/k_rd_packer_t1.sv
// Read-domain packer: pops FIFO entries and packs n_lanes of them into one word.
// Optional K_RDPACK_FLUSH_EN emits partial words after an idle timeout (adds ocnt).
module k_rd_packer_t1 #(
    parameter int data_size    = 8,
    parameter int n_lanes      = 4,
    parameter int flush_cycles = 16
) (
    input  logic                           rclk,
    input  logic                           rrst_n,
    input  logic [data_size-1:0]           rdata,
    input  logic                           rrdy,
    output logic                           rget,
    output logic [n_lanes*data_size-1:0]   odata,
    output logic                           ovalid,
    input  logic                           oready
`ifdef K_RDPACK_FLUSH_EN
    ,
    output logic [$clog2(n_lanes+1)-1:0]   ocnt
`endif
);

    localparam int cw = $clog2(n_lanes + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [cw-1:0]                       cnt;
    logic [cw-1:0]                       cnt_nxt;
    logic [n_lanes-1:0][data_size-1:0]   lanes;
    logic [n_lanes-1:0][data_size-1:0]   lanes_nxt;

    logic accept;
    logic taken;
    logic last_pop;
    logic flush;

    if (n_lanes < 2 || n_lanes > 16 ||
        flush_cycles < 1 || flush_cycles > 255) begin : g_bad_cfg
        $error("k_rd_packer_t1: illegal parameter value");
    end

    // Output word is accepted on this edge
    assign taken    = (state == HOLD) && oready;
    assign last_pop = rget && (state == FILL) &&
                      (cnt == cw'(n_lanes - 1));

`ifdef K_RDPACK_FLUSH_EN
    logic [7:0] idle;
    logic [7:0] idle_nxt;
    logic       idle_run;

    assign idle_run = (state == FILL) && (cnt != '0) && !rrdy;
    assign flush    = idle_run && (idle == 8'(flush_cycles - 1));

    always_comb begin
        idle_nxt = '0;
        if (idle_run && !flush) begin
            idle_nxt = idle + 8'd1;
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            idle <= '0;
        end else begin
            idle <= idle_nxt;
        end
    end
`else
    assign flush = 1'b0;
`endif

    // State register
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL: begin
                if (last_pop || flush) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (oready) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Output logic
    always_comb begin
        accept = (state == FILL) || taken;
        rget   = rrdy && accept;
        ovalid = (state == HOLD);
        odata  = lanes;
`ifdef K_RDPACK_FLUSH_EN
        ocnt   = (state == HOLD) ? cnt : '0;
`endif
    end

    // Lane datapath: clear on acceptance, a pop in HOLD lands in lane 0
    always_comb begin
        cnt_nxt   = cnt;
        lanes_nxt = lanes;
        if (taken) begin
            cnt_nxt   = '0;
            lanes_nxt = '0;
        end
        if (rget) begin
            if (state == HOLD) begin
                lanes_nxt[0] = rdata;
                cnt_nxt      = cw'(1);
            end else begin
                for (int k = 0; k < n_lanes; k++) begin
                    if (cnt == cw'(k)) begin
                        lanes_nxt[k] = rdata;
                    end
                end
                cnt_nxt = cnt + cw'(1);
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            cnt   <= '0;
            lanes <= '0;
        end else begin
            cnt   <= cnt_nxt;
            lanes <= lanes_nxt;
        end
    end

endmodule

// File: tb/tb_k_rd_packer_t1.sv
// Directed bench for k_rd_packer_t1 (n_lanes=4, data_size=8).
// Table vectors plus hand sequences for hold/backpressure and flush.
module tb_k_rd_packer_t1;

    logic        clk;
    logic        rrst_n;
    logic [7:0]  rdata;
    logic        rrdy;
    logic        rget;
    logic [31:0] odata;
    logic        ovalid;
    logic        oready;
`ifdef K_RDPACK_FLUSH_EN
    logic [2:0]  ocnt;
`endif

    int checks = 0;
    int errors = 0;

    k_rd_packer_t1 #(
        .data_size   (8),
        .n_lanes     (4),
        .flush_cycles(16)
    ) dut (
        .rclk  (clk),
        .rrst_n(rrst_n),
        .rdata (rdata),
        .rrdy  (rrdy),
        .rget  (rget),
        .odata (odata),
        .ovalid(ovalid),
        .oready(oready)
`ifdef K_RDPACK_FLUSH_EN
        ,
        .ocnt  (ocnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        rrdy;
        logic [7:0]  rdata;
        logic        oready;
        logic        exp_rget;
        logic        exp_ovalid;
        logic [31:0] exp_odata;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic rs, input logic rr, input logic [7:0] d,
                       input logic orr, input logic eg, input logic ev,
                       input logic [31:0] eo);
        vec_t v;
        v.rst_n = rs; v.rrdy = rr; v.rdata = d; v.oready = orr;
        v.exp_rget = eg; v.exp_ovalid = ev; v.exp_odata = eo;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rrst_n = 1'b0;
        rrdy   = 1'b0;
        rdata  = '0;
        oready = 1'b0;

        // reset state, then 11..44
        add(1, 0, 8'h00, 1, 0, 0, 32'h0000_0000);
        add(1, 1, 8'h11, 1, 1, 0, 32'h0000_0000);
        add(1, 1, 8'h22, 1, 1, 0, 32'h0000_0011);
        add(1, 1, 8'h33, 1, 1, 0, 32'h0000_2211);
        add(1, 1, 8'h44, 1, 1, 0, 32'h0033_2211);
        add(1, 0, 8'h00, 1, 0, 1, 32'h4433_2211);
        add(1, 0, 8'h00, 1, 0, 0, 32'h0000_0000);
        // continuous stream 00..0F
        add(1, 1, 8'h00, 1, 1, 0, 32'h0000_0000);
        add(1, 1, 8'h01, 1, 1, 0, 32'h0000_0000);
        add(1, 1, 8'h02, 1, 1, 0, 32'h0000_0100);
        add(1, 1, 8'h03, 1, 1, 0, 32'h0002_0100);
        add(1, 1, 8'h04, 1, 1, 1, 32'h0302_0100);
        add(1, 1, 8'h05, 1, 1, 0, 32'h0000_0004);
        add(1, 1, 8'h06, 1, 1, 0, 32'h0000_0504);
        add(1, 1, 8'h07, 1, 1, 0, 32'h0006_0504);
        add(1, 1, 8'h08, 1, 1, 1, 32'h0706_0504);
        add(1, 1, 8'h09, 1, 1, 0, 32'h0000_0008);
        add(1, 1, 8'h0A, 1, 1, 0, 32'h0000_0908);
        add(1, 1, 8'h0B, 1, 1, 0, 32'h000A_0908);
        add(1, 1, 8'h0C, 1, 1, 1, 32'h0B0A_0908);
        add(1, 1, 8'h0D, 1, 1, 0, 32'h0000_000C);
        add(1, 1, 8'h0E, 1, 1, 0, 32'h0000_0D0C);
        add(1, 1, 8'h0F, 1, 1, 0, 32'h000E_0D0C);
        add(1, 0, 8'h00, 1, 0, 1, 32'h0F0E_0D0C);
        add(1, 0, 8'h00, 1, 0, 0, 32'h0000_0000);
        // rrdy toggling
        add(1, 1, 8'h21, 1, 1, 0, 32'h0000_0000);
        add(1, 0, 8'h99, 1, 0, 0, 32'h0000_0021);
        add(1, 1, 8'h43, 1, 1, 0, 32'h0000_0021);
        add(1, 0, 8'h99, 1, 0, 0, 32'h0000_4321);
        add(1, 1, 8'h65, 1, 1, 0, 32'h0000_4321);
        add(1, 0, 8'h99, 1, 0, 0, 32'h0065_4321);
        add(1, 1, 8'h87, 1, 1, 0, 32'h0065_4321);
        add(1, 0, 8'h99, 1, 0, 1, 32'h8765_4321);
        add(1, 0, 8'h00, 1, 0, 0, 32'h0000_0000);
        // reset with a partial word
        add(1, 1, 8'hEE, 1, 1, 0, 32'h0000_0000);
        add(1, 1, 8'hFF, 1, 1, 0, 32'h0000_00EE);
        add(0, 0, 8'h00, 1, 0, 0, 32'h0000_FFEE);
        add(1, 1, 8'h01, 1, 1, 0, 32'h0000_0000);
        add(1, 1, 8'h02, 1, 1, 0, 32'h0000_0001);
        add(1, 1, 8'h03, 1, 1, 0, 32'h0000_0201);
        add(1, 1, 8'h04, 1, 1, 0, 32'h0003_0201);
        add(1, 0, 8'h00, 1, 0, 1, 32'h0403_0201);
        add(1, 0, 8'h00, 0, 0, 0, 32'h0000_0000);

        tick();
        tick();

        foreach (tv[i]) begin
            rrst_n = tv[i].rst_n;
            rrdy   = tv[i].rrdy;
            rdata  = tv[i].rdata;
            oready = tv[i].oready;
            #1;
            chk($sformatf("v%0d rget", i), 32'(rget), 32'(tv[i].exp_rget));
            chk($sformatf("v%0d ovalid", i), 32'(ovalid),
                32'(tv[i].exp_ovalid));
            chk($sformatf("v%0d odata", i), odata, tv[i].exp_odata);
            tick();
        end

        // fill with oready low, then hold under backpressure
        rrst_n = 1'b1;
        oready = 1'b0;
        rrdy   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rdata = 8'(8'h10 + i);
            #1;
            chk($sformatf("fill%0d rget", i), 32'(rget), 32'd1);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            rdata = 8'h55;
            #1;
            chk($sformatf("hold%0d rget", i), 32'(rget), 32'd0);
            chk($sformatf("hold%0d ovalid", i), 32'(ovalid), 32'd1);
            chk($sformatf("hold%0d odata", i), odata, 32'h1312_1110);
            tick();
        end
        oready = 1'b1;
        rdata  = 8'hAA;
        #1;
        chk("release rget", 32'(rget), 32'd1);
        tick();
        chk("release ovalid", 32'(ovalid), 32'd0);
        chk("release lane0", odata, 32'h0000_00AA);
        rdata = 8'hBB;
        tick();
        rdata = 8'hCC;
        tick();
        rdata = 8'hDD;
        tick();
        rrdy = 1'b0;
        #1;
        chk("next word ovalid", 32'(ovalid), 32'd1);
        chk("next word odata", odata, 32'hDDCC_BBAA);
        tick();
        chk("next word drop", 32'(ovalid), 32'd0);

`ifdef K_RDPACK_FLUSH_EN
        oready = 1'b0;
        rrdy   = 1'b1;
        rdata  = 8'h5A;
        tick();
        rdata  = 8'hC3;
        tick();
        rrdy   = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("idle%0d ovalid", i), 32'(ovalid),
                (i == 16) ? 32'd1 : 32'd0);
        end
        chk("flush odata", odata, 32'h0000_C35A);
        chk("flush ocnt", 32'(ocnt), 32'd2);
        oready = 1'b1;
        tick();
        chk("flush accept", 32'(ovalid), 32'd0);
        chk("flush ocnt clr", 32'(ocnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
